// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single framebuffer memory port between the
// scanout read requester (priority, starvation bounded) and a linear fill
// engine that writes one constant byte over a contiguous address range.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_STARVE   = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,

    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [3:0] LP_MAX_STARVE = 4'(MAX_STARVE);

    typedef enum logic [0:0] {StIdle, StRun} fill_state_e;

    fill_state_e             r_state;
    logic [ADDR_W-1:0]       r_fill_addr;
    logic [ADDR_W-1:0]       r_fill_rem;
    logic [DATA_W-1:0]       r_fill_value;
    logic                    r_fill_done;
    logic [3:0]              r_starve;
    logic                    r_mem_cs;
    logic                    r_mem_write;
    logic [ADDR_W-1:0]       r_mem_address;
    logic [DATA_W-1:0]       r_mem_writedata;
    logic [READ_LATENCY-1:0] r_rd_pipe;

    logic w_fill_pending;
    logic w_scan_gnt;
    logic w_fill_gnt;
    logic w_rd_issue;

    // A fill write is pending for every cycle the engine is running.
    assign w_fill_pending = (r_state == StRun);
    // Scan has priority until it has been granted MAX_STARVE times in a row over a pending fill.
    assign w_scan_gnt     = scan_req && (r_starve < LP_MAX_STARVE);
    assign w_fill_gnt     = w_fill_pending && !w_scan_gnt;
    // A read strobe is on the bus this cycle.
    assign w_rd_issue     = r_mem_cs && !r_mem_write;

    assign scan_gnt       = w_scan_gnt;
    assign scan_rvalid    = r_rd_pipe[READ_LATENCY-1];
    assign scan_rdata     = mem_readdata;
    assign fill_busy      = w_fill_pending;
    assign fill_done      = r_fill_done;
    assign mem_address    = r_mem_address;
    assign mem_chipselect = r_mem_cs;
    assign mem_clken      = 1'b1;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;

    // Fill sequencer: latches the command, walks the address range, pulses done.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= StIdle;
            r_fill_addr  <= '0;
            r_fill_rem   <= '0;
            r_fill_value <= '0;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (fill_start) begin
                        if (fill_len != '0) begin
                            r_fill_addr  <= fill_base;
                            r_fill_rem   <= fill_len;
                            r_fill_value <= fill_value;
                            r_state      <= StRun;
                        end else begin
                            // Zero-length fill completes immediately without touching the bus.
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // fill_start is ignored here; the running command is kept.
                    if (w_fill_gnt) begin
                        r_fill_addr <= r_fill_addr + 1'b1;
                        r_fill_rem  <= r_fill_rem - 1'b1;
                        if (r_fill_rem == ADDR_W'(1)) begin
                            // Done lands in the same cycle as the last write on the bus.
                            r_state     <= StIdle;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Starve counter: counts scan grants taken over a pending fill, saturating.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_starve <= '0;
        end else if (!w_fill_pending || w_fill_gnt) begin
            r_starve <= '0;
        end else if (w_scan_gnt && (r_starve < LP_MAX_STARVE)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Registered bus strobes; address and data hold their last values on idle cycles.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mem_cs        <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else begin
            r_mem_cs    <= w_scan_gnt || w_fill_gnt;
            r_mem_write <= w_fill_gnt;
            if (w_scan_gnt) begin
                r_mem_address <= scan_addr;
            end else if (w_fill_gnt) begin
                r_mem_address   <= r_fill_addr;
                r_mem_writedata <= r_fill_value;
            end
        end
    end

    // Read-valid pipe: follows each read strobe by READ_LATENCY cycles.
    if (READ_LATENCY > 1) begin : g_rd_pipe_deep
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_rd_pipe <= '0;
            end else begin
                r_rd_pipe <= {r_rd_pipe[READ_LATENCY-2:0], w_rd_issue};
            end
        end
    end else begin : g_rd_pipe_single
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_rd_pipe <= '0;
            end else begin
                r_rd_pipe <= w_rd_issue;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: cycle-stepped stimulus, a small memory model
// and scoreboard queues of expected/observed bus writes, reads and done pulses.
`timescale 1ns/1ps
module tb_fb_port_arbiter;

    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned READ_LATENCY = 1;
    localparam int unsigned MAX_STARVE   = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic              scan_rvalid;
    logic [DATA_W-1:0] scan_rdata;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    fb_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY),
        .MAX_STARVE   (MAX_STARVE)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .scan_req       (scan_req),
        .scan_addr      (scan_addr),
        .scan_gnt       (scan_gnt),
        .scan_rvalid    (scan_rvalid),
        .scan_rdata     (scan_rdata),
        .fill_start     (fill_start),
        .fill_base      (fill_base),
        .fill_len       (fill_len),
        .fill_value     (fill_value),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t               exp_wr[$];
    ev_t               obs_wr[$];
    ev_t               exp_rd[$];
    ev_t               obs_rd[$];
    logic [ADDR_W-1:0] obs_rdaddr[$];
    int                obs_done[$];
    logic [DATA_W-1:0] mem_model[int];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // Outputs as sampled in the most recently stepped cycle.
    logic              s_gnt;
    logic              s_busy;
    logic              s_cs;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic ev_t mk_ev(input int c, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
        ev_t r;
        r.cyc  = 32'(c);
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic void clear_queues();
        exp_wr.delete();
        obs_wr.delete();
        exp_rd.delete();
        obs_rd.delete();
        obs_rdaddr.delete();
        obs_done.delete();
    endfunction

    // One clock cycle: sample at negedge, record events, answer reads after the edge.
    task automatic step();
        ev_t               e;
        logic              rd_now;
        logic [ADDR_W-1:0] rd_a;
        @(negedge clk_clk);
        s_gnt  = scan_gnt;
        s_busy = fill_busy;
        s_cs   = mem_chipselect;
        s_we   = mem_write;
        s_addr = mem_address;
        rd_now = mem_chipselect && !mem_write;
        rd_a   = mem_address;
        if (scan_gnt) exp_rd.push_back(mk_ev(cyc + 1 + int'(READ_LATENCY), scan_addr,
                                             mem_rd(scan_addr)));
        if (scan_rvalid) begin
            e = mk_ev(cyc, '0, scan_rdata);
            obs_rd.push_back(e);
        end
        if (mem_chipselect && mem_write) begin
            obs_wr.push_back(mk_ev(cyc, mem_address, mem_writedata));
            mem_model[int'(mem_address)] = mem_writedata;
        end
        if (rd_now) obs_rdaddr.push_back(mem_address);
        if (fill_done) obs_done.push_back(cyc);
        @(posedge clk_clk);
        #1;
        if (rd_now) mem_readdata = mem_rd(rd_a);
        cyc++;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b1;
        #2 reset_reset_n = 1'b0;
        #1;
        checks++;
        if ({scan_gnt, scan_rvalid, fill_busy, fill_done, mem_chipselect, mem_write,
             mem_address, mem_writedata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got cs=%b we=%b addr=%h wd=%h busy=%b done=%b rv=%b, need all 0",
                     mem_chipselect, mem_write, mem_address, mem_writedata, fill_busy,
                     fill_done, scan_rvalid);
        end
        checks++;
        if (mem_clken !== 1'b1) begin
            failures++;
            $display("FAIL reset_clken: got %b, need 1", mem_clken);
        end
        repeat (3) step();
        reset_reset_n = 1'b1;
        repeat (2) step();
        checks++;
        if ({s_cs, s_busy, s_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle: got cs/busy/gnt=%b, need 000", {s_cs, s_busy, s_gnt});
        end
    endtask

    task automatic test_plain_fill();
        int         t;
        logic [7:0] busy_v;
        clear_queues();
        t = cyc;
        fill_base  = 19'h00010;
        fill_len   = 19'd4;
        fill_value = 8'hA5;
        fill_start = 1'b1;
        for (int i = 0; i < 4; i++) exp_wr.push_back(mk_ev(t + 2 + i, ADDR_W'(32'h10 + i), 8'hA5));
        for (int k = 0; k < 8; k++) begin
            step();
            fill_start = 1'b0;
            busy_v[k]  = s_busy;
        end
        checks++;
        if (busy_v !== 8'b0001_1110) begin
            failures++;
            $display("FAIL plain_fill busy: got %b, need %b", busy_v, 8'b0001_1110);
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL plain_fill write_count: got %0d, need %0d", obs_wr.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL plain_fill write%0d: got cyc=%0d addr=%h data=%h, need cyc=%0d addr=%h data=%h",
                         i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].data,
                         exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != t + 5) begin
            failures++;
            $display("FAIL plain_fill done: got %0d pulses first at %0d, need 1 at %0d",
                     obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, t + 5);
        end
    endtask

    task automatic test_scan_read();
        int t;
        clear_queues();
        mem_model[int'(19'h12345)] = 8'h3C;
        t = cyc;
        scan_addr = 19'h12345;
        scan_req  = 1'b1;
        step();
        scan_req = 1'b0;
        checks++;
        if (s_gnt !== 1'b1) begin
            failures++;
            $display("FAIL scan_read gnt: got %b, need 1", s_gnt);
        end
        step();
        checks++;
        if ({s_cs, s_we, s_addr} !== {1'b1, 1'b0, 19'h12345}) begin
            failures++;
            $display("FAIL scan_read bus: got cs=%b we=%b addr=%h, need cs=1 we=0 addr=12345",
                     s_cs, s_we, s_addr);
        end
        repeat (3) step();
        checks++;
        if (obs_rd.size() != 1) begin
            failures++;
            $display("FAIL scan_read rvalid_count: got %0d, need 1", obs_rd.size());
        end else begin
            checks++;
            if (obs_rd[0].cyc !== 32'(t + 2) || obs_rd[0].data !== 8'h3C) begin
                failures++;
                $display("FAIL scan_read rdata: got cyc=%0d data=%h, need cyc=%0d data=3c",
                         obs_rd[0].cyc, obs_rd[0].data, t + 2);
            end
        end
    endtask

    task automatic test_starvation();
        int                t;
        int                lows[$];
        logic [ADDR_W-1:0] a;
        clear_queues();
        t          = cyc;
        a          = 19'h40000;
        scan_addr  = a;
        scan_req   = 1'b1;
        fill_base  = 19'h00200;
        fill_len   = 19'd3;
        fill_value = 8'h77;
        fill_start = 1'b1;
        for (int i = 0; i < 3; i++) exp_wr.push_back(mk_ev(t + 6 + 5 * i, ADDR_W'(32'h200 + i), 8'h77));
        for (int k = 0; k < 22; k++) begin
            step();
            fill_start = 1'b0;
            if (s_gnt) begin
                a         = a + 1'b1;
                scan_addr = a;
            end else begin
                lows.push_back(cyc - 1);
            end
        end
        scan_req = 1'b0;
        repeat (4) step();
        checks++;
        if (lows.size() != 3) begin
            failures++;
            $display("FAIL starve gnt_low_count: got %0d, need 3", lows.size());
        end
        foreach (lows[i]) if (i < 3) begin
            checks++;
            if (lows[i] != t + 5 * (i + 1)) begin
                failures++;
                $display("FAIL starve gnt_low%0d: got cycle %0d, need %0d", i, lows[i], t + 5 * (i + 1));
            end
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL starve write_count: got %0d, need %0d", obs_wr.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL starve write%0d: got cyc=%0d addr=%h data=%h, need cyc=%0d addr=%h data=%h",
                         i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].data,
                         exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != t + 16) begin
            failures++;
            $display("FAIL starve done: got %0d pulses, need 1 at %0d", obs_done.size(), t + 16);
        end
        checks++;
        if (exp_rd.size() != 19 || obs_rd.size() != 19 || obs_rdaddr.size() != 19) begin
            failures++;
            $display("FAIL starve read_count: got grants=%0d strobes=%0d rvalid=%0d, need 19 each",
                     exp_rd.size(), obs_rdaddr.size(), obs_rd.size());
        end
        foreach (exp_rd[i]) if (i < obs_rd.size() && i < obs_rdaddr.size()) begin
            checks++;
            if (obs_rdaddr[i] !== ADDR_W'(32'h40000 + i) || obs_rd[i].cyc !== exp_rd[i].cyc ||
                obs_rd[i].data !== exp_rd[i].data) begin
                failures++;
                $display("FAIL starve read%0d: got addr=%h cyc=%0d data=%h, need addr=%h cyc=%0d data=%h",
                         i, obs_rdaddr[i], obs_rd[i].cyc, obs_rd[i].data,
                         ADDR_W'(32'h40000 + i), exp_rd[i].cyc, exp_rd[i].data);
            end
        end
    endtask

    task automatic test_wrap_zero();
        int         t;
        logic [3:0] cs_v;
        logic [3:0] busy_v;
        clear_queues();
        t          = cyc;
        fill_base  = 19'h7FFFE;
        fill_len   = 19'd3;
        fill_value = 8'hC3;
        fill_start = 1'b1;
        exp_wr.push_back(mk_ev(t + 2, 19'h7FFFE, 8'hC3));
        exp_wr.push_back(mk_ev(t + 3, 19'h7FFFF, 8'hC3));
        exp_wr.push_back(mk_ev(t + 4, 19'h00000, 8'hC3));
        for (int k = 0; k < 7; k++) begin
            step();
            fill_start = 1'b0;
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL wrap write_count: got %0d, need %0d", obs_wr.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL wrap write%0d: got cyc=%0d addr=%h data=%h, need cyc=%0d addr=%h data=%h",
                         i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].data,
                         exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != t + 4) begin
            failures++;
            $display("FAIL wrap done: got %0d pulses, need 1 at %0d", obs_done.size(), t + 4);
        end
        clear_queues();
        t          = cyc;
        fill_base  = 19'h00055;
        fill_len   = 19'd0;
        fill_value = 8'h11;
        fill_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            fill_start = 1'b0;
            cs_v[k]    = s_cs;
            busy_v[k]  = s_busy;
        end
        checks++;
        if (cs_v !== 4'b0000 || busy_v !== 4'b0000 || obs_wr.size() != 0) begin
            failures++;
            $display("FAIL zero_len bus: got cs=%b busy=%b writes=%0d, need cs=0000 busy=0000 writes=0",
                     cs_v, busy_v, obs_wr.size());
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != t + 1) begin
            failures++;
            $display("FAIL zero_len done: got %0d pulses, need 1 at %0d", obs_done.size(), t + 1);
        end
    endtask

    task automatic test_ignored_restart();
        int t;
        clear_queues();
        t          = cyc;
        fill_base  = 19'h00000;
        fill_len   = 19'd8;
        fill_value = 8'h3E;
        fill_start = 1'b1;
        for (int i = 0; i < 8; i++) exp_wr.push_back(mk_ev(t + 2 + i, ADDR_W'(i), 8'h3E));
        for (int k = 0; k < 12; k++) begin
            step();
            fill_start = (k == 2);
            if (k == 2) begin
                fill_base  = 19'h00100;
                fill_len   = 19'd2;
                fill_value = 8'hFF;
            end
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL restart write_count: got %0d, need %0d", obs_wr.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL restart write%0d: got cyc=%0d addr=%h data=%h, need cyc=%0d addr=%h data=%h",
                         i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].data,
                         exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] != t + 9) begin
            failures++;
            $display("FAIL restart done: got %0d pulses, need 1 at %0d", obs_done.size(), t + 9);
        end
    endtask

    task automatic test_reset_mid_fill();
        int t;
        clear_queues();
        t          = cyc;
        fill_base  = 19'h00300;
        fill_len   = 19'd10;
        fill_value = 8'h99;
        fill_start = 1'b1;
        scan_addr  = 19'h41000;
        for (int i = 0; i < 3; i++) exp_wr.push_back(mk_ev(t + 2 + i, ADDR_W'(32'h300 + i), 8'h99));
        for (int k = 0; k < 5; k++) begin
            step();
            fill_start = 1'b0;
            scan_req   = (k == 3);
        end
        checks++;
        if (s_gnt !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid read_gnt: got %b, need 1", s_gnt);
        end
        reset_reset_n = 1'b0;
        #1;
        checks++;
        if ({scan_gnt, scan_rvalid, fill_busy, fill_done, mem_chipselect, mem_write,
             mem_address, mem_writedata} !== '0 || mem_clken !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid outputs: got cs=%b we=%b addr=%h wd=%h busy=%b rv=%b clken=%b, need 0s with clken=1",
                     mem_chipselect, mem_write, mem_address, mem_writedata, fill_busy,
                     scan_rvalid, mem_clken);
        end
        repeat (2) step();
        reset_reset_n = 1'b1;
        repeat (15) step();
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL reset_mid write_count: got %0d, need %0d", obs_wr.size(), exp_wr.size());
        end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL reset_mid write%0d: got cyc=%0d addr=%h data=%h, need cyc=%0d addr=%h data=%h",
                         i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].data,
                         exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
            end
        end
        checks++;
        if (obs_done.size() != 0 || obs_rd.size() != 0) begin
            failures++;
            $display("FAIL reset_mid aftermath: got done=%0d rvalid=%0d, need 0 and 0",
                     obs_done.size(), obs_rd.size());
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        scan_req      = 1'b0;
        scan_addr     = '0;
        fill_start    = 1'b0;
        fill_base     = '0;
        fill_len      = '0;
        fill_value    = '0;
        mem_readdata  = '0;
        test_reset();
        test_plain_fill();
        test_scan_read();
        test_starvation();
        test_wrap_zero();
        test_ignored_restart();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbiter and fill sequencer for the 8-bit, 19-bit-address framebuffer memory port exported by the Nios system (`mem_*` slave). It shares that single port between a high-priority scanout read requester and a built-in rectangle-less linear fill engine that writes a constant byte over a contiguous address range. Sits in the top level between the video scanout logic and the system's `mem_*` port, so the CPU-side of the memory is untouched.

## Interface

- `ADDR_W`, 19, memory word address width
- `DATA_W`, 8, memory data width
- `READ_LATENCY`, 1, cycles from `mem_*` read strobe to valid `mem_readdata`; legal values 1–3
- `MAX_STARVE`, 4, consecutive scan grants allowed while a fill write is pending; legal range 1–15

- `clk_clk` in 1: the only clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `scan_req` in 1: scanout requests one read this cycle.
- `scan_addr` in ADDR_W: scanout read address.
- `scan_gnt` out 1: combinational; the read is accepted this cycle.
- `scan_rvalid` out 1: read data valid, one cycle per grant.
- `scan_rdata` out DATA_W: read data, direct from `mem_readdata`.
- `fill_start` in 1: single-cycle fill command.
- `fill_base` in ADDR_W: first fill address.
- `fill_len` in ADDR_W: number of bytes to write.
- `fill_value` in DATA_W: byte to write.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle completion pulse.
- `mem_address` out ADDR_W: to system `mem_address`.
- `mem_chipselect` out 1: to system `mem_chipselect`.
- `mem_clken` out 1: to system `mem_clken`, constant 1.
- `mem_write` out 1: to system `mem_write`.
- `mem_writedata` out DATA_W: to system `mem_writedata`.
- `mem_readdata` in DATA_W: from system `mem_readdata`.

## Operation

- **Fill FSM states:** IDLE, RUN.
  - IDLE:
    - `fill_start` with `fill_len` ≠ 0: latch base, len and value; go to RUN; `fill_busy` = 1 from the next cycle.
    - `fill_start` with `fill_len` = 0: no writes; `fill_done` pulses the next cycle; stay IDLE.
  - RUN:
    - A fill write is pending every cycle.
    - On each fill grant: current address +1, modulo 2^ADDR_W (0x7FFFF wraps to 0x00000); remaining −1.
    - When the grant consumes the last byte: return to IDLE and drop `fill_busy` the next cycle.
  - `fill_start` while in RUN is ignored; latched values are unchanged.
- **Arbitration, evaluated each cycle:**
  - Scan wins when `scan_req` = 1 and the starve counter < MAX_STARVE.
  - Otherwise a pending fill wins.
  - Otherwise the cycle is idle.
- **Starve counter:**
  - +1 on every scan grant while a fill is pending, saturating at MAX_STARVE.
  - Cleared on a fill grant, or whenever no fill is pending.
- When fill is forced in, `scan_gnt` = 0 that cycle; the scan requester holds `scan_req`/`scan_addr` and retries.
- **Granted scan read:** next cycle `mem_chipselect` = 1, `mem_write` = 0, `mem_address` = `scan_addr`.
- **Granted fill write:** next cycle `mem_chipselect` = 1, `mem_write` = 1, address = current fill address, `mem_writedata` = value.
- **Idle cycle:** `mem_chipselect` = 0, `mem_write` = 0; address and data hold their last values.
- **Read tracking:** a READ_LATENCY-deep valid shift register follows issued reads. `scan_rvalid` is its output; `scan_rdata` = `mem_readdata`.

## Timing

- **Scan read:** `scan_gnt` in cycle t; bus strobe in t+1; `scan_rvalid` in t+1+READ_LATENCY. Back-to-back grants give back-to-back `scan_rvalid`, in order.
- **Fill command:** `fill_start` in cycle t. First fill grant possible in t+1; first write on the bus in t+2.
- **Fill completion:** `fill_done` pulses in the same cycle the last write is on the bus. `fill_busy` falls in that same cycle.
- **Throughput:** with no scan traffic, a fill of N bytes occupies N consecutive bus cycles.
- **Throughput under continuous `scan_req`:** the fill gets exactly 1 of every MAX_STARVE+1 cycles.
- **Reset values:**
  - `mem_clken` = 1.
  - All other outputs 0, including `mem_address`/`mem_writedata`.
  - FSM in IDLE; starve counter 0; read-valid pipe cleared.
- **Reset mid-operation:**
  - An in-progress fill is aborted; no `fill_done`.
  - In-flight reads are dropped; no `scan_rvalid` after reset release.

## Test plan

- **Plain fill:** fill base 0x00010, len 4, value 0xA5, `scan_req` = 0 -> writes of 0xA5 to 0x10, 0x11, 0x12, 0x13 on cycles t+2..t+5; `fill_done` at t+5; `fill_busy` high t+1..t+4.
- **Scan read latency:** `scan_req` for 0x12345 at t, READ_LATENCY = 1, memory returns 0x3C -> `scan_gnt` at t; `mem_address` 0x12345 with cs = 1, write = 0 at t+1; `scan_rvalid` with 0x3C at t+2.
- **Starvation:** MAX_STARVE = 4, `scan_req` held high, fill len 3 started at t -> `scan_gnt` low on exactly 3 cycles, spaced every 5th cycle. Verify the scan address order is preserved and exactly one `scan_rvalid` is produced per grant.
- **Wrap and zero length:**
  - Base 0x7FFFE, len 3 -> writes to 0x7FFFE, 0x7FFFF, 0x00000.
  - Len 0 -> `fill_done` at t+1; no chipselect; `fill_busy` stays 0.
- **Ignored restart:** `fill_start` (base 0x100, len 2) pulsed during a running fill (base 0x0, len 8) -> exactly 8 writes, to 0x0..0x7; a single `fill_done`.
- **Reset mid-fill:** assert `reset_reset_n` low after 3 of 10 writes, with a read in flight -> all outputs at reset values immediately. After release: no further writes, no `fill_done`, no `scan_rvalid`.
